// File: rtl/reader_pie_tx.sv
// reader_pie_tx: reader-side Gen2 PIE downlink transmitter.
// Emits delimiter, data-0, RTcal, optional TRcal, then the PIE-encoded payload
// (MSB first), pulling payload bits from an external source through dataclk.
// Optional feature: define PIE_TX_CRC16_EN to let docrc append an inverted CRC-16.
module reader_pie_tx #(
    parameter int DELIM_CYC = 25,
    parameter int TARI_CYC  = 25,
    parameter int PW_CYC    = 12,
    parameter int RTCAL_CYC = 63,
    parameter int TRCAL_CYC = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       preamble,
    input  logic [6:0] nbits,
    input  logic       docrc,
    input  logic       databit,
    output logic       dataclk,
    output logic       pieout,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELIM = 3'd1,
        ST_D0    = 3'd2,
        ST_RTCAL = 3'd3,
        ST_TRCAL = 3'd4,
        ST_DATA  = 3'd5,
        ST_CRC   = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    localparam logic [9:0] DELIM_L = 10'(DELIM_CYC);
    localparam logic [9:0] TARI_L  = 10'(TARI_CYC);
    localparam logic [9:0] PW_L    = 10'(PW_CYC);
    localparam logic [9:0] RTCAL_L = 10'(RTCAL_CYC);
    localparam logic [9:0] TRCAL_L = 10'(TRCAL_CYC);
    localparam logic [9:0] D1_L    = 10'(RTCAL_CYC - TARI_CYC);

    state_t     state_r, state_s, tail_state_s;
    logic [9:0] cnt_r, cnt_s;
    logic [9:0] len_r, len_s, len_cur_s, tail_len_s;
    logic [6:0] bitcnt_r, bitcnt_s;
    logic [6:0] nbits_r;
    logic       pre_r;
    logic       sym_end_s;
    logic       pieout_s;

`ifdef PIE_TX_CRC16_EN
    logic        crc_en_r;
    logic [15:0] crc_r, crc_s;

    // CRC-16/CCITT single-bit update, polynomial 0x1021
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        crc16_step = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction
`else
    logic unused_docrc_s;
    assign unused_docrc_s = docrc;
`endif

    // Next-state, symbol counter and symbol length selection
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r + 10'd1;
        len_s    = len_r;
        bitcnt_s = bitcnt_r;
`ifdef PIE_TX_CRC16_EN
        crc_s    = crc_r;
        // the CRC register is final by the end of the last data symbol
        if (crc_en_r) begin
            tail_state_s = ST_CRC;
            tail_len_s   = crc_r[15] ? TARI_L : D1_L;
        end else begin
            tail_state_s = ST_DONE;
            tail_len_s   = len_r;
        end
`else
        tail_state_s = ST_DONE;
        tail_len_s   = len_r;
`endif
        // a data symbol's length is only known once databit is sampled in its first cycle
        if (state_r == ST_DATA && cnt_r == 10'd0) begin
            len_cur_s = databit ? D1_L : TARI_L;
        end else begin
            len_cur_s = len_r;
        end
        sym_end_s = (cnt_r == len_cur_s - 10'd1);

        case (state_r)
            ST_IDLE: begin
                cnt_s = 10'd0;
                if (start) begin
                    state_s  = ST_DELIM;
                    len_s    = DELIM_L;
                    bitcnt_s = 7'd0;
`ifdef PIE_TX_CRC16_EN
                    crc_s    = 16'hFFFF;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DELIM: begin
                if (sym_end_s) begin
                    state_s = ST_D0;
                    cnt_s   = 10'd0;
                    len_s   = TARI_L;
                end else begin
                    state_s = ST_DELIM;
                end
            end
            ST_D0: begin
                if (sym_end_s) begin
                    state_s = ST_RTCAL;
                    cnt_s   = 10'd0;
                    len_s   = RTCAL_L;
                end else begin
                    state_s = ST_D0;
                end
            end
            ST_RTCAL, ST_TRCAL: begin
                if (sym_end_s && state_r == ST_RTCAL && pre_r) begin
                    state_s = ST_TRCAL;
                    cnt_s   = 10'd0;
                    len_s   = TRCAL_L;
                end else if (sym_end_s) begin
                    cnt_s    = 10'd0;
                    bitcnt_s = 7'd0;
                    if (nbits_r != 7'd0) begin
                        state_s = ST_DATA;
                        len_s   = TARI_L;
                    end else begin
                        state_s = tail_state_s;
                        len_s   = tail_len_s;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_DATA: begin
                len_s = len_cur_s;
`ifdef PIE_TX_CRC16_EN
                if (cnt_r == 10'd0) begin
                    crc_s = crc16_step(crc_r, databit);
                end else begin
                    crc_s = crc_r;
                end
`endif
                if (sym_end_s) begin
                    cnt_s = 10'd0;
                    if (bitcnt_r + 7'd1 == nbits_r) begin
                        bitcnt_s = 7'd0;
                        state_s  = tail_state_s;
                        len_s    = tail_len_s;
                    end else begin
                        bitcnt_s = bitcnt_r + 7'd1;
                        state_s  = ST_DATA;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
`ifdef PIE_TX_CRC16_EN
            ST_CRC: begin
                if (sym_end_s) begin
                    cnt_s = 10'd0;
                    crc_s = {crc_r[14:0], 1'b1};
                    if (bitcnt_r == 7'd15) begin
                        state_s = ST_DONE;
                    end else begin
                        bitcnt_s = bitcnt_r + 7'd1;
                        len_s    = crc_r[14] ? TARI_L : D1_L;
                        state_s  = ST_CRC;
                    end
                end else begin
                    state_s = ST_CRC;
                end
            end
`endif
            ST_DONE: begin
                state_s = ST_IDLE;
                cnt_s   = 10'd0;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 10'd0;
            end
        endcase

        // envelope for the upcoming cycle: high phase then PW_CYC low at symbol end
        case (state_s)
            ST_IDLE, ST_DONE: pieout_s = 1'b1;
            ST_DELIM:         pieout_s = 1'b0;
            default:          pieout_s = (cnt_s < len_s - PW_L);
        endcase
    end

    // FSM state, counters, captured frame options and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 10'd0;
            len_r    <= 10'd0;
            bitcnt_r <= 7'd0;
            nbits_r  <= 7'd0;
            pre_r    <= 1'b0;
            pieout   <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            dataclk  <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            len_r    <= len_s;
            bitcnt_r <= bitcnt_s;
            if (state_r == ST_IDLE && start) begin
                nbits_r <= nbits;
                pre_r   <= preamble;
            end else begin
                nbits_r <= nbits_r;
                pre_r   <= pre_r;
            end
            pieout  <= pieout_s;
            busy    <= (state_s != ST_IDLE) && (state_s != ST_DONE);
            done    <= (state_s == ST_DONE);
            dataclk <= (state_s == ST_DATA) && (cnt_s == 10'd0);
        end
    end

`ifdef PIE_TX_CRC16_EN
    // CRC register and the CRC-enable captured at frame start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc_r    <= 16'hFFFF;
            crc_en_r <= 1'b0;
        end else begin
            crc_r <= crc_s;
            if (state_r == ST_IDLE && start) begin
                crc_en_r <= docrc;
            end else begin
                crc_en_r <= crc_en_r;
            end
        end
    end
`endif

endmodule
